// File: rtl/serial_loader.sv
// serial_loader: UART-driven boot monitor sitting in front of the cpu.
// Parses 'L' (load bytes into RAM) and 'G' (ack, then start cpu at address)
// commands, owns the RAM write port and UART TX while the cpu is idle, and
// hands the bus to the cpu until it reports HLT.
//
// Build option: define LOADER_CHECKSUM_EN to append an 8-bit mod-256 sum of
// the loaded data bytes after the 'K' ack of every L command.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a command byte, other bytes dropped
// ADDRH      | waiting for address high byte
// ADDRL      | waiting for address low byte
// LEN        | waiting for L length byte (0 means 256)
// DATA       | writing each received data byte to RAM, cnt counts down
// ACK_WAIT   | waiting for the UART to be idle before sending 'K'
// ACK_SEND   | 'K' strobe cycle, then one guard cycle
// CSUM_WAIT  | (checksum build) waiting for UART idle before sending sum
// CSUM_SEND  | (checksum build) sum strobe cycle, then one guard cycle
// START      | pulse cpu_start, release the bus
// RUN        | cpu owns RX/TX/RAM; waiting for cpu_halted

module serial_loader #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [7:0]            wdata,
  output logic                  write_en,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] startaddr,
  input  logic                  cpu_halted,
  output logic                  owns_bus
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] ACK_CHAR = 8'h4B;

  typedef enum logic [3:0] {
    IDLE,
    ADDRH,
    ADDRL,
    LEN,
    DATA,
    ACK_WAIT,
    ACK_SEND,
`ifdef LOADER_CHECKSUM_EN
    CSUM_WAIT,
    CSUM_SEND,
`endif
    START,
    RUN
  } state_t;

  state_t                state;
  logic                  is_load;   // current command is L (else G)
  logic                  guard;     // second cycle of a send state
  logic [ADDR_WIDTH-1:0] addr;      // parsed address, also the L write pointer
  logic [8:0]            cnt;       // remaining data bytes, down-counter
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // Command parser, RAM write/TX sequencing and bus ownership; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_load   <= 1'b0;
      guard     <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
      tx_byte   <= '0;
      transmit  <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      write_en  <= 1'b0;
      cpu_start <= 1'b0;
      startaddr <= '0;
      owns_bus  <= 1'b1;
    end else begin
      transmit  <= 1'b0;
      write_en  <= 1'b0;
      cpu_start <= 1'b0;

      unique case (state)
        IDLE: begin
          if (received) begin
            if (rx_byte == CMD_LOAD) begin
              is_load <= 1'b1;
              state   <= ADDRH;
            end else if (rx_byte == CMD_GO) begin
              is_load <= 1'b0;
              state   <= ADDRH;
            end
          end
        end

        ADDRH: begin
          if (received) begin
            // Only the low ADDR_WIDTH-8 bits of the high byte are meaningful.
            addr[ADDR_WIDTH-1:8] <= rx_byte[ADDR_WIDTH-9:0];
            state                <= ADDRL;
          end
        end

        ADDRL: begin
          if (received) begin
            addr[7:0] <= rx_byte;
            state     <= is_load ? LEN : ACK_WAIT;
          end
        end

        LEN: begin
          if (received) begin
            cnt   <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
            state <= DATA;
          end
        end

        DATA: begin
          if (received) begin
            write_en <= 1'b1;
            waddr    <= addr;
            wdata    <= rx_byte;
            addr     <= addr + ADDR_WIDTH'(1);
            cnt      <= cnt - 9'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum + rx_byte;
`endif
            if (cnt == 9'd1) state <= ACK_WAIT;
          end
        end

        ACK_WAIT: begin
          if (!is_transmitting) begin
            tx_byte  <= ACK_CHAR;
            transmit <= 1'b1;
            guard    <= 1'b0;
            state    <= ACK_SEND;
          end
        end

        // First cycle carries the strobe; the guard cycle gives the UART time
        // to raise is_transmitting before anyone samples it again.
        ACK_SEND: begin
          if (!guard) begin
            guard <= 1'b1;
          end else begin
            guard <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            state <= is_load ? CSUM_WAIT : START;
`else
            state <= is_load ? IDLE : START;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CSUM_WAIT: begin
          if (!is_transmitting) begin
            tx_byte  <= csum;
            transmit <= 1'b1;
            guard    <= 1'b0;
            state    <= CSUM_SEND;
          end
        end

        CSUM_SEND: begin
          if (!guard) begin
            guard <= 1'b1;
          end else begin
            guard <= 1'b0;
            state <= IDLE;
          end
        end
`endif

        START: begin
          startaddr <= addr;
          cpu_start <= 1'b1;
          owns_bus  <= 1'b0;
          state     <= RUN;
        end

        RUN: begin
          if (cpu_halted) begin
            owns_bus <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: feeds byte commands and compares the
// captured RAM writes, TX strobes and cpu start pulses with hand-computed values.
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       is_transmitting = 1'b0;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [8:0] waddr;
  logic [7:0] wdata;
  logic       write_en;
  logic       cpu_start;
  logic [8:0] startaddr;
  logic       cpu_halted = 1'b0;
  logic       owns_bus;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] tx_q[$];
  int         start_cnt = 0;

  serial_loader #(.ADDR_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .waddr(waddr), .wdata(wdata), .write_en(write_en), .cpu_start(cpu_start),
    .startaddr(startaddr), .cpu_halted(cpu_halted), .owns_bus(owns_bus)
  );

  always #5 clk = ~clk;

  // Capture every strobe away from the active edge.
  always @(negedge clk) begin
    if (write_en) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
    if (transmit) tx_q.push_back(tx_byte);
    if (cpu_start) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic clr;
    @(posedge clk);
    wa_q.delete();
    wd_q.delete();
    tx_q.delete();
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int start_base;

  initial begin
    // 1: reset state, stray byte dropped
    cycles(2);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_startaddr", startaddr, 0);
    chk("rst_owns_bus", owns_bus, 1);
    rst = 1'b0;
    send(8'h55);
    cycles(4);
    chk("stray_writes", wa_q.size(), 0);
    chk("stray_tx", tx_q.size(), 0);

    // 2: basic load
    clr();
    send(8'h4C); send(8'h00); send(8'h10); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    cycles(12);
    chk("ld_nwr", wa_q.size(), 3);
    chk("ld_a0", wa_q[0], 9'h010); chk("ld_d0", wd_q[0], 8'hAA);
    chk("ld_a1", wa_q[1], 9'h011); chk("ld_d1", wd_q[1], 8'hBB);
    chk("ld_a2", wa_q[2], 9'h012); chk("ld_d2", wd_q[2], 8'hCC);
`ifdef LOADER_CHECKSUM_EN
    chk("ld_ntx", tx_q.size(), 2);
    chk("ld_csum", tx_q[1], 8'h31);
`else
    chk("ld_ntx", tx_q.size(), 1);
`endif
    chk("ld_ack", tx_q[0], 8'h4B);

    // 3: address wrap, then len=0 meaning 256
    clr();
    send(8'h4C); send(8'h01); send(8'hFF); send(8'h02);
    send(8'h11); send(8'h22);
    cycles(12);
    chk("wrap_nwr", wa_q.size(), 2);
    chk("wrap_a0", wa_q[0], 9'h1FF); chk("wrap_d0", wd_q[0], 8'h11);
    chk("wrap_a1", wa_q[1], 9'h000); chk("wrap_d1", wd_q[1], 8'h22);
    clr();
    send(8'h4C); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    cycles(12);
    chk("l256_nwr", wa_q.size(), 256);
    chk("l256_a0", wa_q[0], 9'h000);
    chk("l256_a255", wa_q[255], 9'h0FF);
    chk("l256_d128", wd_q[128], 8'h80);
    chk("l256_d255", wd_q[255], 8'hFF);
`ifdef LOADER_CHECKSUM_EN
    chk("l256_ntx", tx_q.size(), 2);
    chk("l256_csum", tx_q[1], 8'h80);
`else
    chk("l256_ntx", tx_q.size(), 1);
`endif

    // 4: go, RX ignored while running, halt returns to IDLE
    clr();
    start_base = start_cnt;
    send(8'h47); send(8'h01); send(8'h23);
    cycles(10);
    chk("go_ntx", tx_q.size(), 1);
    chk("go_ack", tx_q[0], 8'h4B);
    chk("go_nstart", start_cnt - start_base, 1);
    chk("go_startaddr", startaddr, 9'h123);
    chk("go_owns_bus", owns_bus, 0);
    send(8'h4C); send(8'h00); send(8'h00); send(8'h01); send(8'h77);
    cycles(10);
    chk("run_nwr", wa_q.size(), 0);
    chk("run_ntx", tx_q.size(), 1);
    chk("run_startaddr_hold", startaddr, 9'h123);
    @(negedge clk); cpu_halted = 1'b1;
    @(negedge clk); cpu_halted = 1'b0;
    cycles(2);
    chk("halt_owns_bus", owns_bus, 1);
    send(8'h4C); send(8'h00); send(8'h20); send(8'h01); send(8'h5A);
    cycles(12);
    chk("post_halt_nwr", wa_q.size(), 1);
    chk("post_halt_a", wa_q[0], 9'h020);
    chk("post_halt_d", wd_q[0], 8'h5A);

    // 5: ack held off by busy UART
    clr();
    is_transmitting = 1'b1;
    send(8'h4C); send(8'h00); send(8'h30); send(8'h01); send(8'h99);
    cycles(10);
    chk("busy_nwr", wa_q.size(), 1);
    chk("busy_ntx", tx_q.size(), 0);
    is_transmitting = 1'b0;
    cycles(12);
`ifdef LOADER_CHECKSUM_EN
    chk("busy_rel_ntx", tx_q.size(), 2);
    chk("busy_rel_csum", tx_q[1], 8'h99);
`else
    chk("busy_rel_ntx", tx_q.size(), 1);
`endif
    chk("busy_rel_ack", tx_q[0], 8'h4B);

    // 6: reset aborts a partial load; next G parses cleanly
    clr();
    start_base = start_cnt;
    send(8'h4C); send(8'h00); send(8'h00); send(8'h05); send(8'hAA);
    pulse_rst();
    cycles(2);
    chk("abort_nwr", wa_q.size(), 1);
    chk("abort_owns_bus", owns_bus, 1);
    send(8'h47); send(8'h00); send(8'h00);
    cycles(10);
    chk("abort_nwr_after", wa_q.size(), 1);
    chk("abort_ntx", tx_q.size(), 1);
    chk("abort_ack", tx_q[0], 8'h4B);
    chk("abort_nstart", start_cnt - start_base, 1);
    chk("abort_startaddr", startaddr, 9'h000);
    chk("abort_go_owns_bus", owns_bus, 0);

    // reset while running hands the bus back
    pulse_rst();
    cycles(1);
    chk("run_rst_owns_bus", owns_bus, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
